// File: rtl/dmac_req_scheduler.sv
// dmac_req_scheduler
// Front-end sequencer for the DMA controller. Round-robin arbitration over
// the peripheral request lines, ReqAck handshake with the winner, system bus
// negotiation, datapath start, HReady stall watchdog during the transfer and
// sticky per-channel done/error status feeding a registered interrupt.
//
// Ports:
//   clk, rst               rising-edge clock, asynchronous active-high reset
//   DmacReq   [NUM_CH]     level requests from the peripherals
//   ReqAck    [NUM_CH]     one-hot acknowledge to the winning peripheral
//   Bus_Req / Bus_Grant    system bus request / grant
//   HReady                 AHB ready from the slave mux
//   Xfer_Done, Xfer_Err    one-cycle completion / error pulses from the datapath
//   Ch_Sel    [NUM_CH]     one-hot active channel (config set select)
//   Xfer_Start             one-cycle start pulse to the datapath
//   Xfer_Hold              datapath stall while the grant is lost in ACTIVE
//   Xfer_Abort             one-cycle abort pulse (error or watchdog timeout)
//   Irq_Clr   [NUM_CH]     write-1 clear of both status vectors
//   Done_Status/Err_Status sticky per-channel completion / error flags
//   Busy                   high whenever the sequencer is not idle
//   Interrupt              registered OR of all status bits
module dmac_req_scheduler #(
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] DmacReq,
    output logic [NUM_CH-1:0] ReqAck,
    output logic              Bus_Req,
    input  logic              Bus_Grant,
    input  logic              HReady,
    input  logic              Xfer_Done,
    input  logic              Xfer_Err,
    output logic [NUM_CH-1:0] Ch_Sel,
    output logic              Xfer_Start,
    output logic              Xfer_Hold,
    output logic              Xfer_Abort,
    input  logic [NUM_CH-1:0] Irq_Clr,
    output logic [NUM_CH-1:0] Done_Status,
    output logic [NUM_CH-1:0] Err_Status,
    output logic              Busy,
    output logic              Interrupt
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]  LAST_RST    = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    NUM_CH_W    = (CH_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
    localparam logic [NUM_CH-1:0] ONE_HOT0   = {{(NUM_CH - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_GRANT_WAIT,
        S_START,
        S_ACTIVE,
        S_RELEASE
    } state_t;

    state_t            state;
    logic [CH_W-1:0]   last_ch;
    logic [CH_W-1:0]   winner;
    logic [CH_W-1:0]   pick;
    logic              pick_valid;
    logic [CH_W:0]     rr_idx;
    logic [CNT_W-1:0]  watchdog;
    logic              stall;
    logic              timeout_hit;
    logic              abort_now;
    logic [NUM_CH-1:0] pick_oh;
    logic [NUM_CH-1:0] winner_oh;
    logic [NUM_CH-1:0] done_set;
    logic [NUM_CH-1:0] err_set;

    // Round-robin search starting just above the last served channel.
    // rr_idx is one bit wider so last_ch + k can be wrapped by subtraction.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        rr_idx     = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            rr_idx = {1'b0, last_ch} + (CH_W + 1)'(k);
            if (rr_idx >= NUM_CH_W) begin
                rr_idx = rr_idx - NUM_CH_W;
            end
            if (!pick_valid && DmacReq[rr_idx[CH_W-1:0]]) begin
                pick_valid = 1'b1;
                pick       = rr_idx[CH_W-1:0];
            end
        end
    end

    assign pick_oh   = ONE_HOT0 << pick;
    assign winner_oh = ONE_HOT0 << winner;

    // A stall cycle is one where the bus is ours but the slave is not ready.
    // The abort fires at the edge where the counter would reach the limit,
    // so the pulse appears in the cycle right after the last stall cycle.
    assign stall       = Bus_Grant & ~HReady;
    assign timeout_hit = (TIMEOUT_CYC != 0) && stall &&
                         ((watchdog + CNT_W'(1)) == TIMEOUT_VAL);
    assign abort_now   = Xfer_Err | timeout_hit;

    // Error beats completion when both arrive together.
    assign done_set = (state == S_ACTIVE && !abort_now && Xfer_Done) ? winner_oh : '0;
    assign err_set  = (state == S_ACTIVE && abort_now) ? winner_oh : '0;

    assign Busy      = (state != S_IDLE);
    assign Xfer_Hold = (state == S_ACTIVE) && !Bus_Grant;

    // Sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ReqAck     <= '0;
            Ch_Sel     <= '0;
            Bus_Req    <= 1'b0;
            Xfer_Start <= 1'b0;
            Xfer_Abort <= 1'b0;
            last_ch    <= LAST_RST;
            winner     <= '0;
            watchdog   <= '0;
        end else begin
            Xfer_Start <= 1'b0;
            Xfer_Abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        winner  <= pick;
                        Ch_Sel  <= pick_oh;
                        ReqAck  <= pick_oh;
                        Bus_Req <= 1'b1;
                        state   <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!DmacReq[winner]) begin
                        ReqAck <= '0;
                        state  <= S_GRANT_WAIT;
                    end
                end
                S_GRANT_WAIT: begin
                    if (Bus_Grant && HReady) begin
                        Xfer_Start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    // Counter freezes while the grant is lost.
                    if (HReady) begin
                        watchdog <= '0;
                    end else if (Bus_Grant) begin
                        watchdog <= watchdog + CNT_W'(1);
                    end
                    if (abort_now) begin
                        Xfer_Abort <= 1'b1;
                        Bus_Req    <= 1'b0;
                        Ch_Sel     <= '0;
                        state      <= S_RELEASE;
                    end else if (Xfer_Done) begin
                        Bus_Req <= 1'b0;
                        Ch_Sel  <= '0;
                        state   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    last_ch  <= winner;
                    watchdog <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky status: a set in the same cycle as a clear keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Done_Status <= '0;
            Err_Status  <= '0;
            Interrupt   <= 1'b0;
        end else begin
            Done_Status <= (Done_Status & ~Irq_Clr) | done_set;
            Err_Status  <= (Err_Status & ~Irq_Clr) | err_set;
            Interrupt   <= (|Done_Status) | (|Err_Status);
        end
    end

endmodule

// File: tb/tb_dmac_req_scheduler.sv
// tb_dmac_req_scheduler
// Self-checking bench for dmac_req_scheduler with three channels and an
// eight-cycle stall limit. Directed scenarios plus a randomized run checked
// against a transaction-level model (served channel, status vectors).
module tb_dmac_req_scheduler;

    localparam int N  = 3;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] dmac_req;
    logic [N-1:0] req_ack;
    logic         bus_req;
    logic         bus_grant;
    logic         hready;
    logic         xfer_done;
    logic         xfer_err;
    logic [N-1:0] ch_sel;
    logic         xfer_start;
    logic         xfer_hold;
    logic         xfer_abort;
    logic [N-1:0] irq_clr;
    logic [N-1:0] done_status;
    logic [N-1:0] err_status;
    logic         busy;
    logic         irq;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: last served channel and sticky status.
    int           last_m;
    logic [N-1:0] done_m;
    logic [N-1:0] err_m;

    dmac_req_scheduler #(
        .NUM_CH      (N),
        .TIMEOUT_CYC (TO),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .DmacReq     (dmac_req),
        .ReqAck      (req_ack),
        .Bus_Req     (bus_req),
        .Bus_Grant   (bus_grant),
        .HReady      (hready),
        .Xfer_Done   (xfer_done),
        .Xfer_Err    (xfer_err),
        .Ch_Sel      (ch_sel),
        .Xfer_Start  (xfer_start),
        .Xfer_Hold   (xfer_hold),
        .Xfer_Abort  (xfer_abort),
        .Irq_Clr     (irq_clr),
        .Done_Status (done_status),
        .Err_Status  (err_status),
        .Busy        (busy),
        .Interrupt   (irq)
    );

    always #5 clk = ~clk;

    // Hard stop in case the DUT wedges somewhere no bounded loop covers.
    initial begin
        #300000;
        $display("[TB] FAIL sim_timeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] oh(input int c);
        logic [N-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        dmac_req  = '0;
        bus_grant = 1'b0;
        hready    = 1'b1;
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
        irq_clr   = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        last_m = N - 1;
        done_m = '0;
        err_m  = '0;
    endtask

    // Walks one request from IDLE into ACTIVE with an immediate grant.
    task automatic drive_to_active(input logic [N-1:0] req);
        dmac_req = req;
        tick();
        dmac_req = '0;
        tick();
        bus_grant = 1'b1;
        hready    = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst       = 1'b1;
        dmac_req  = 3'b111;
        xfer_done = 1'b1;
        bus_grant = 1'b1;
        tick();
        tick();
        vectors++;
        if ({req_ack, ch_sel, done_status, err_status} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_vectors: got %h expected 000", {req_ack, ch_sel, done_status, err_status});
        end
        vectors++;
        if ({bus_req, xfer_start, xfer_hold, xfer_abort, busy, irq} !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 000000", {bus_req, xfer_start, xfer_hold, xfer_abort, busy, irq});
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if ({busy, bus_req, req_ack} !== 5'b00000) begin
            miscompares++;
            $display("[TB] FAIL reset_release_idle: got %b expected 00000", {busy, bus_req, req_ack});
        end
    endtask

    task automatic test_basic();
        do_reset();
        dmac_req = 3'b011;
        tick();
        vectors++;
        if ({req_ack, bus_req, busy} !== 5'b00111) begin
            miscompares++;
            $display("[TB] FAIL basic_ack: got %b expected 00111", {req_ack, bus_req, busy});
        end
        dmac_req = 3'b010;
        tick();
        vectors++;
        if ({req_ack, bus_req} !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL basic_ack_drop: got %b expected 0001", {req_ack, bus_req});
        end
        bus_grant = 1'b1;
        tick();
        vectors++;
        if ({xfer_start, ch_sel} !== 4'b1001) begin
            miscompares++;
            $display("[TB] FAIL basic_start: got %b expected 1001", {xfer_start, ch_sel});
        end
        tick();
        vectors++;
        if (xfer_start !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_start_width: got %b expected 0", xfer_start);
        end
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        vectors++;
        if ({done_status, err_status, bus_req, ch_sel, xfer_abort, irq} !== 11'b001_000_0_000_0_0) begin
            miscompares++;
            $display("[TB] FAIL basic_release: got %b expected 00100000000", {done_status, err_status, bus_req, ch_sel, xfer_abort, irq});
        end
        tick();
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL basic_irq: got %b expected 1", irq);
        end
        tick();
        vectors++;
        if (req_ack !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL basic_rr_next: got %b expected 010", req_ack);
        end
        dmac_req = '0;
        tick();
        tick();
        tick();
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        tick();
        vectors++;
        if (done_status !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL basic_done2: got %b expected 011", done_status);
        end
    endtask

    task automatic test_back_to_back();
        int exp_ch;
        do_reset();
        dmac_req = 3'b011;
        for (int i = 0; i < 4; i++) begin
            exp_ch = i % 2;
            tick();
            vectors++;
            if (req_ack !== oh(exp_ch)) begin
                miscompares++;
                $display("[TB] FAIL b2b_ack[%0d]: got %b expected %b", i, req_ack, oh(exp_ch));
            end
            dmac_req = 3'b011 & ~oh(exp_ch);
            tick();
            dmac_req  = 3'b011;
            bus_grant = 1'b1;
            tick();
            tick();
            xfer_done = 1'b1;
            tick();
            xfer_done = 1'b0;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_grant_hold();
        do_reset();
        drive_to_active(3'b100);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus_grant = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if ({xfer_hold, xfer_abort} !== 2'b10) begin
                miscompares++;
                $display("[TB] FAIL hold_cycle[%0d]: got %b expected 10", i, {xfer_hold, xfer_abort});
            end
            tick();
        end
        bus_grant = 1'b1;
        #1;
        vectors++;
        if (xfer_hold !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_release: got %b expected 0", xfer_hold);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({xfer_abort, bus_req} !== 2'b01) begin
                miscompares++;
                $display("[TB] FAIL hold_wd_frozen[%0d]: got %b expected 01", i, {xfer_abort, bus_req});
            end
        end
        hready    = 1'b1;
        xfer_done = 1'b1;
        tick();
        xfer_done = 1'b0;
        vectors++;
        if ({done_status, err_status, xfer_abort} !== 7'b100_000_0) begin
            miscompares++;
            $display("[TB] FAIL hold_complete: got %b expected 1000000", {done_status, err_status, xfer_abort});
        end
        tick();
    endtask

    task automatic test_timeout();
        drive_to_active(3'b001);
        hready = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (i < TO) begin
                vectors++;
                if ({xfer_abort, bus_req} !== 2'b01) begin
                    miscompares++;
                    $display("[TB] FAIL timeout_early[%0d]: got %b expected 01", i, {xfer_abort, bus_req});
                end
            end
        end
        vectors++;
        if ({xfer_abort, bus_req, err_status, done_status} !== 8'b1_0_001_100) begin
            miscompares++;
            $display("[TB] FAIL timeout_abort: got %b expected 10001100", {xfer_abort, bus_req, err_status, done_status});
        end
        hready = 1'b1;
        tick();
        vectors++;
        if ({xfer_abort, busy} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL timeout_pulse_width: got %b expected 00", {xfer_abort, busy});
        end
    endtask

    task automatic test_done_err_clear();
        drive_to_active(3'b010);
        xfer_done = 1'b1;
        xfer_err  = 1'b1;
        irq_clr   = 3'b010;
        tick();
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
        vectors++;
        if ({err_status, done_status, xfer_abort} !== 7'b011_100_1) begin
            miscompares++;
            $display("[TB] FAIL err_wins_set_wins: got %b expected 0111001", {err_status, done_status, xfer_abort});
        end
        irq_clr = 3'b111;
        tick();
        irq_clr = '0;
        vectors++;
        if ({err_status, done_status, irq} !== 7'b000_000_1) begin
            miscompares++;
            $display("[TB] FAIL clear_status: got %b expected 0000001", {err_status, done_status, irq});
        end
        tick();
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clear_irq: got %b expected 0", irq);
        end
    endtask

    task automatic test_reset_mid();
        drive_to_active(3'b001);
        #1;
        xfer_done = 1'b1;
        rst       = 1'b1;
        #1;
        vectors++;
        if ({bus_req, busy, req_ack, ch_sel} !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_async_drop: got %b expected 00000000", {bus_req, busy, req_ack, ch_sel});
        end
        tick();
        vectors++;
        if ({done_status, err_status} !== 6'b000000) begin
            miscompares++;
            $display("[TB] FAIL reset_no_status: got %b expected 000000", {done_status, err_status});
        end
        idle_inputs();
        dmac_req = 3'b111;
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++;
        if (req_ack !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL reset_rr_restart: got %b expected 001", req_ack);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        logic [N-1:0] clr;
        logic [N-1:0] exp_oh;
        logic         exp_irq;
        logic         exp_abort;
        logic         g;
        logic         h;
        int           w;
        int           outcome;
        int           wd;
        int           n;
        do_reset();
        for (int t = 0; t < 24; t++) begin
            req     = N'($urandom_range(1, (1 << N) - 1));
            clr     = N'($urandom_range(0, (1 << N) - 1));
            w       = rr_pick(req, last_m);
            exp_oh  = oh(w);
            exp_irq = |(done_m | err_m);
            dmac_req = req;
            irq_clr  = clr;
            tick();
            irq_clr = '0;
            done_m  = done_m & ~clr;
            err_m   = err_m & ~clr;
            vectors++;
            if ({req_ack, bus_req, irq} !== {exp_oh, 1'b1, exp_irq}) begin
                miscompares++;
                $display("[TB] FAIL rnd_ack[%0d]: got %b expected %b", t, {req_ack, bus_req, irq}, {exp_oh, 1'b1, exp_irq});
            end
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                dmac_req = N'($urandom) | exp_oh;
                tick();
                vectors++;
                if (req_ack !== exp_oh) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_ack_hold[%0d]: got %b expected %b", t, req_ack, exp_oh);
                end
            end
            dmac_req = N'($urandom) & ~exp_oh;
            tick();
            vectors++;
            if (req_ack !== '0) begin
                miscompares++;
                $display("[TB] FAIL rnd_ack_drop[%0d]: got %b expected 000", t, req_ack);
            end
            n = $urandom_range(0, 3);
            for (int i = 0; i < n; i++) begin
                bus_grant = 1'b0;
                hready    = 1'($urandom_range(0, 1));
                xfer_done = 1'($urandom_range(0, 1));
                xfer_err  = 1'($urandom_range(0, 1));
                tick();
                vectors++;
                if ({xfer_start, bus_req, done_status, err_status} !== {1'b0, 1'b1, done_m, err_m}) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_grant_wait[%0d]: got %b expected %b", t, {xfer_start, bus_req, done_status, err_status}, {1'b0, 1'b1, done_m, err_m});
                end
            end
            xfer_done = 1'b0;
            xfer_err  = 1'b0;
            bus_grant = 1'b1;
            hready    = 1'b1;
            tick();
            vectors++;
            if ({xfer_start, ch_sel} !== {1'b1, exp_oh}) begin
                miscompares++;
                $display("[TB] FAIL rnd_start[%0d]: got %b expected %b", t, {xfer_start, ch_sel}, {1'b1, exp_oh});
            end
            tick();
            outcome = t % 4;
            wd      = 0;
            if (outcome != 3) begin
                n = $urandom_range(0, 5);
                for (int i = 0; i < n; i++) begin
                    g = 1'($urandom_range(0, 1));
                    h = 1'($urandom_range(0, 1));
                    bus_grant = g;
                    hready    = h;
                    #1;
                    vectors++;
                    if (xfer_hold !== ~g) begin
                        miscompares++;
                        $display("[TB] FAIL rnd_hold[%0d]: got %b expected %b", t, xfer_hold, ~g);
                    end
                    tick();
                end
                clr       = N'($urandom_range(0, (1 << N) - 1));
                bus_grant = 1'($urandom_range(0, 1));
                hready    = 1'b1;
                irq_clr   = clr;
                xfer_done = (outcome != 1);
                xfer_err  = (outcome != 0);
                tick();
                done_m    = (done_m & ~clr) | ((outcome == 0) ? exp_oh : '0);
                err_m     = (err_m & ~clr) | ((outcome != 0) ? exp_oh : '0);
                exp_abort = (outcome != 0);
            end else begin
                for (int i = 0; i < 40 && wd < TO; i++) begin
                    g = (i >= 20) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
                    bus_grant = g;
                    hready    = 1'b0;
                    tick();
                    if (g) wd++;
                    if (wd < TO) begin
                        vectors++;
                        if (xfer_abort !== 1'b0) begin
                            miscompares++;
                            $display("[TB] FAIL rnd_early_abort[%0d]: got %b expected 0 (stalls %0d)", t, xfer_abort, wd);
                        end
                    end
                end
                err_m     = err_m | exp_oh;
                exp_abort = 1'b1;
            end
            irq_clr   = '0;
            xfer_done = 1'b0;
            xfer_err  = 1'b0;
            hready    = 1'b1;
            vectors++;
            if ({xfer_abort, bus_req, ch_sel, done_status, err_status} !== {exp_abort, 1'b0, 3'b000, done_m, err_m}) begin
                miscompares++;
                $display("[TB] FAIL rnd_release[%0d]: got %b expected %b", t, {xfer_abort, bus_req, ch_sel, done_status, err_status}, {exp_abort, 1'b0, 3'b000, done_m, err_m});
            end
            bus_grant = 1'b0;
            tick();
            last_m = w;
            vectors++;
            if ({irq, busy, xfer_abort} !== {|(done_m | err_m), 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL rnd_idle[%0d]: got %b expected %b", t, {irq, busy, xfer_abort}, {|(done_m | err_m), 1'b0, 1'b0});
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        last_m = N - 1;
        done_m = '0;
        err_m  = '0;
        $display("[TB] starting dmac_req_scheduler bench");
        test_reset();
        test_basic();
        test_back_to_back();
        test_grant_hold();
        test_timeout();
        test_done_err_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
